// File: rtl/io_tdm_deserializer.sv
// Single-wire TDM receiver: steers the k-th valid bit of a frame into par_out[k].
// Optional even-parity trailer bit enabled by defining IO_TDM_PARITY_EN.
module io_tdm_deserializer #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ser_in,
  input  logic             i_ser_valid,
  input  logic             i_ser_sof,
  output logic [WIDTH-1:0] o_par_out,
  output logic             o_par_valid,
  output logic             o_frame_err,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_bit_cnt
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef IO_TDM_PARITY_EN
  localparam int unsigned LAST_IDX = WIDTH;
`else
  localparam int unsigned LAST_IDX = WIDTH - 1;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_IDX);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_par_out;
  logic             r_par_valid;
  logic             r_frame_err;
  logic             r_busy;

  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] w_bit_cnt_nxt;
  logic [WIDTH-1:0] w_shadow_nxt;
  logic [WIDTH-1:0] w_par_out_nxt;
  logic             w_par_valid_nxt;
  logic             w_frame_err_nxt;

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shadow    <= '0;
      r_par_out   <= '0;
      r_par_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shadow    <= w_shadow_nxt;
      r_par_out   <= w_par_out_nxt;
      r_par_valid <= w_par_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_busy      <= (w_state_nxt == S_SHIFT);
    end
  end

  // Next-state and datapath decode; nothing moves while ser_valid is low
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shadow_nxt    = r_shadow;
    w_par_out_nxt   = r_par_out;
    w_par_valid_nxt = 1'b0;
    w_frame_err_nxt = 1'b0;
    if (i_ser_valid) begin
      case (r_state)
        S_IDLE: begin
          if (i_ser_sof) begin
            w_shadow_nxt[0] = i_ser_in;
            w_bit_cnt_nxt   = CNT_W'(1);
            w_state_nxt     = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (i_ser_sof) begin
            // A new sof aborts the partial frame and restarts at index 0
            w_frame_err_nxt = 1'b1;
            w_shadow_nxt[0] = i_ser_in;
            w_bit_cnt_nxt   = CNT_W'(1);
          end else if (r_bit_cnt == LAST) begin
`ifdef IO_TDM_PARITY_EN
            if ((^r_shadow) ^ i_ser_in) begin
              w_frame_err_nxt = 1'b1;
            end else begin
              w_par_out_nxt   = r_shadow;
              w_par_valid_nxt = 1'b1;
            end
`else
            w_shadow_nxt[IDX_W'(r_bit_cnt)] = i_ser_in;
            w_par_out_nxt   = w_shadow_nxt;
            w_par_valid_nxt = 1'b1;
`endif
            w_bit_cnt_nxt = '0;
            w_state_nxt   = S_IDLE;
          end else begin
            w_shadow_nxt[IDX_W'(r_bit_cnt)] = i_ser_in;
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt   = S_IDLE;
          w_bit_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign o_par_out   = r_par_out;
  assign o_par_valid = r_par_valid;
  assign o_frame_err = r_frame_err;
  assign o_busy      = r_busy;
  assign o_bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_io_tdm_deserializer.sv
// Directed bench for io_tdm_deserializer: WIDTH=8 instance plus a WIDTH=512 instance.
module tb_io_tdm_deserializer;

  localparam int unsigned W   = 8;
  localparam int unsigned CW  = 4;
  localparam int unsigned WW  = 512;
  localparam int unsigned WCW = 10;
`ifdef IO_TDM_PARITY_EN
  localparam int NB  = 9;
  localparam int WNB = 513;
`else
  localparam int NB  = 8;
  localparam int WNB = 512;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ser_in = 1'b0, ser_valid = 1'b0, ser_sof = 1'b0;
  logic [W-1:0]  par_out;
  logic          par_valid, frame_err, busy;
  logic [CW-1:0] bit_cnt;

  logic           w_ser_in = 1'b0, w_ser_valid = 1'b0, w_ser_sof = 1'b0;
  logic [WW-1:0]  w_par_out;
  logic           w_par_valid, w_frame_err, w_busy;
  logic [WCW-1:0] w_bit_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  io_tdm_deserializer #(.WIDTH(W), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_ser_in(ser_in), .i_ser_valid(ser_valid),
    .i_ser_sof(ser_sof), .o_par_out(par_out), .o_par_valid(par_valid),
    .o_frame_err(frame_err), .o_busy(busy), .o_bit_cnt(bit_cnt)
  );

  io_tdm_deserializer #(.WIDTH(WW), .CNT_W(WCW)) dut_wide (
    .i_clk(clk), .i_rst(rst), .i_ser_in(w_ser_in), .i_ser_valid(w_ser_valid),
    .i_ser_sof(w_ser_sof), .o_par_out(w_par_out), .o_par_valid(w_par_valid),
    .o_frame_err(w_frame_err), .o_busy(w_busy), .o_bit_cnt(w_bit_cnt)
  );

  // Bit k of a frame: data bits first, then the even-parity bit
  function automatic logic fbit(input logic [7:0] d, input int k);
    if (k < 8) return d[3'(k)];
    return ^d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input logic s);
    ser_in = b; ser_valid = 1'b1; ser_sof = s;
    tick();
  endtask

  task automatic idle_in();
    ser_in = 1'b0; ser_valid = 1'b0; ser_sof = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_in();
    tick(); tick();
    checks++; if (par_out !== 8'h00) begin errors++; $display("FAIL reset_par_out got %h want 00", par_out); end
    checks++; if (par_valid !== 1'b0) begin errors++; $display("FAIL reset_par_valid got %b want 0", par_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL reset_bit_cnt got %0d want 0", bit_cnt); end
    rst = 1'b0;
    tick();
    drive(1'b1, 1'b0);
    checks++; if (busy !== 1'b0 || bit_cnt !== 4'd0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL idle_nosof busy=%b cnt=%0d err=%b want 0/0/0", busy, bit_cnt, frame_err);
    end
    idle_in();
    tick();
  endtask

  task automatic test_basic();
    for (int k = 0; k < NB; k++) begin
      drive(fbit(8'hA5, k), k == 0);
      if (k < NB - 1) begin
        checks++; if (busy !== 1'b1 || par_valid !== 1'b0) begin
          errors++; $display("FAIL basic_mid k=%0d busy=%b pv=%b want 1/0", k, busy, par_valid);
        end
      end
    end
    checks++; if (par_valid !== 1'b1) begin errors++; $display("FAIL basic_par_valid got %b want 1", par_valid); end
    checks++; if (par_out !== 8'hA5) begin errors++; $display("FAIL basic_par_out got %h want a5", par_out); end
    checks++; if (busy !== 1'b0 || bit_cnt !== 4'd0) begin
      errors++; $display("FAIL basic_done busy=%b cnt=%0d want 0/0", busy, bit_cnt);
    end
    idle_in();
    tick();
    checks++; if (par_valid !== 1'b0 || par_out !== 8'hA5) begin
      errors++; $display("FAIL basic_after pv=%b out=%h want 0/a5", par_valid, par_out);
    end
  endtask

  task automatic test_gap();
    int err_seen = 0;
    for (int k = 0; k < 3; k++) begin
      drive(fbit(8'h3C, k), k == 0);
      if (frame_err) err_seen++;
    end
    idle_in();
    for (int g = 0; g < 3; g++) begin
      tick();
      checks++; if (bit_cnt !== 4'd3 || busy !== 1'b1) begin
        errors++; $display("FAIL gap_hold g=%0d cnt=%0d busy=%b want 3/1", g, bit_cnt, busy);
      end
      if (frame_err) err_seen++;
    end
    for (int k = 3; k < NB; k++) begin
      drive(fbit(8'h3C, k), 1'b0);
      if (frame_err) err_seen++;
    end
    checks++; if (par_valid !== 1'b1 || par_out !== 8'h3C) begin
      errors++; $display("FAIL gap_result pv=%b out=%h want 1/3c", par_valid, par_out);
    end
    checks++; if (err_seen != 0) begin errors++; $display("FAIL gap_no_err got %0d want 0", err_seen); end
    idle_in();
    tick();
  endtask

  task automatic test_abort();
    for (int k = 0; k < 5; k++) drive(fbit(8'h55, k), k == 0);
    drive(fbit(8'hF0, 0), 1'b1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL abort_err got %b want 1", frame_err); end
    checks++; if (par_out !== 8'h3C || par_valid !== 1'b0) begin
      errors++; $display("FAIL abort_hold out=%h pv=%b want 3c/0", par_out, par_valid);
    end
    checks++; if (bit_cnt !== 4'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_restart cnt=%0d busy=%b want 1/1", bit_cnt, busy);
    end
    for (int k = 1; k < NB; k++) begin
      drive(fbit(8'hF0, k), 1'b0);
      if (k == 1) begin
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL abort_pulse got %b want 0", frame_err); end
      end
    end
    checks++; if (par_valid !== 1'b1 || par_out !== 8'hF0) begin
      errors++; $display("FAIL abort_result pv=%b out=%h want 1/f0", par_valid, par_out);
    end
    idle_in();
    tick();
  endtask

  task automatic test_back_to_back();
    int t1;
    for (int k = 0; k < NB; k++) drive(fbit(8'h01, k), k == 0);
    t1 = cyc;
    checks++; if (par_valid !== 1'b1 || par_out !== 8'h01) begin
      errors++; $display("FAIL b2b_first pv=%b out=%h want 1/01", par_valid, par_out);
    end
    for (int k = 0; k < NB; k++) begin
      drive(fbit(8'h80, k), k == 0);
      if (k == 0) begin
        checks++; if (par_valid !== 1'b0 || busy !== 1'b1 || frame_err !== 1'b0) begin
          errors++; $display("FAIL b2b_restart pv=%b busy=%b err=%b want 0/1/0", par_valid, busy, frame_err);
        end
      end
    end
    checks++; if (par_valid !== 1'b1 || par_out !== 8'h80) begin
      errors++; $display("FAIL b2b_second pv=%b out=%h want 1/80", par_valid, par_out);
    end
    checks++; if (cyc - t1 != NB) begin errors++; $display("FAIL b2b_spacing got %0d want %0d", cyc - t1, NB); end
    idle_in();
    tick();
  endtask

  task automatic test_reset_mid();
    int pv_seen = 0;
    for (int k = 0; k < 4; k++) drive(fbit(8'hFF, k), k == 0);
    idle_in();
    rst = 1'b1;
    #1;
    checks++; if (par_out !== 8'h00 || busy !== 1'b0 || bit_cnt !== 4'd0 || par_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs out=%h busy=%b cnt=%0d pv=%b want 00/0/0/0", par_out, busy, bit_cnt, par_valid);
    end
    tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < NB; k++) begin
      drive(fbit(8'h0F, k), k == 0);
      if (k < NB - 1 && par_valid) pv_seen++;
    end
    checks++; if (pv_seen != 0) begin errors++; $display("FAIL rstmid_stale_pv got %0d want 0", pv_seen); end
    checks++; if (par_valid !== 1'b1 || par_out !== 8'h0F) begin
      errors++; $display("FAIL rstmid_result pv=%b out=%h want 1/0f", par_valid, par_out);
    end
    idle_in();
    tick();
  endtask

`ifdef IO_TDM_PARITY_EN
  task automatic test_parity();
    for (int k = 0; k < 9; k++) drive(fbit(8'hA5, k), k == 0);
    checks++; if (par_valid !== 1'b1 || frame_err !== 1'b0 || par_out !== 8'hA5) begin
      errors++; $display("FAIL parity_good pv=%b err=%b out=%h want 1/0/a5", par_valid, frame_err, par_out);
    end
    for (int k = 0; k < 8; k++) drive(fbit(8'h5A, k), k == 0);
    drive(~fbit(8'h5A, 8), 1'b0);
    checks++; if (par_valid !== 1'b0 || frame_err !== 1'b1) begin
      errors++; $display("FAIL parity_bad_flags pv=%b err=%b want 0/1", par_valid, frame_err);
    end
    checks++; if (par_out !== 8'hA5 || busy !== 1'b0 || bit_cnt !== 4'd0) begin
      errors++; $display("FAIL parity_bad_hold out=%h busy=%b cnt=%0d want a5/0/0", par_out, busy, bit_cnt);
    end
    idle_in();
    tick();
  endtask
`endif

  task automatic test_wide();
    logic [WW-1:0] wd;
    for (int i = 0; i < 16; i++) wd[i*32 +: 32] = $urandom;
    for (int k = 0; k < WNB; k++) begin
      w_ser_in    = (k < 512) ? wd[9'(k)] : ^wd;
      w_ser_valid = 1'b1;
      w_ser_sof   = (k == 0);
      tick();
    end
    w_ser_valid = 1'b0; w_ser_sof = 1'b0; w_ser_in = 1'b0;
    checks++; if (w_par_valid !== 1'b1 || w_frame_err !== 1'b0 || w_busy !== 1'b0) begin
      errors++; $display("FAIL wide_flags pv=%b err=%b busy=%b want 1/0/0", w_par_valid, w_frame_err, w_busy);
    end
    checks++; if (w_par_out !== wd || w_bit_cnt !== 10'd0) begin
      errors++; $display("FAIL wide_par_out got %h want %h cnt=%0d", w_par_out[63:0], wd[63:0], w_bit_cnt);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef IO_TDM_PARITY_EN
    test_parity();
`endif
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
